// File: rtl/uart_pkg.sv
// Shared UART receiver types and constants.
// Optional 8E1 framing is enabled by UART_RX_PARITY_EN.
package uart_pkg;

  localparam int UART_DATA_BITS = 8;
  localparam int UART_DEFAULT_CLKS_PER_BIT = 434;

  typedef enum logic [2:0] {
    IDLE,
    START,
    DATA,
    PARITY,
    STOP,
    WAIT_HIGH
  } rx_state_e;

endpackage

// File: rtl/rx_byte_fifo.sv
// First-word-fall-through byte FIFO for the UART receiver.
// Head reads as zero while empty.
module rx_byte_fifo
  import uart_pkg::*;
#(
  parameter int FIFO_DEPTH = 4
) (
  input  logic                          clk,
  input  logic                          rst,
  input  logic                          push,
  input  logic [UART_DATA_BITS-1:0]     push_data,
  input  logic                          pop,
  output logic [UART_DATA_BITS-1:0]     rd_data,
  output logic                          full,
  output logic                          empty,
  output logic [$clog2(FIFO_DEPTH):0]   count
);

  localparam int AW = $clog2(FIFO_DEPTH);
  localparam int CW = AW + 1;

  logic [UART_DATA_BITS-1:0] mem [FIFO_DEPTH];
  logic [AW-1:0]             wptr;
  logic [AW-1:0]             rptr;
  logic                      do_push;
  logic                      do_pop;

  assign empty   = (count == '0);
  assign full    = (count == CW'(FIFO_DEPTH));
  assign do_pop  = pop & ~empty;
  assign do_push = push & (~full | do_pop);
  assign rd_data = empty ? '0 : mem[rptr];

  // Pointer and occupancy bookkeeping; pointers wrap naturally.
  always_ff @(posedge clk) begin
    if (rst) begin
      wptr  <= '0;
      rptr  <= '0;
      count <= '0;
    end else begin
      if (do_push) wptr <= wptr + 1'b1;
      if (do_pop)  rptr <= rptr + 1'b1;
      unique case ({do_push, do_pop})
        2'b10:   count <= count + 1'b1;
        2'b01:   count <= count - 1'b1;
        default: count <= count;
      endcase
    end
  end

  // Byte storage; contents need no reset.
  always_ff @(posedge clk) begin
    if (do_push) mem[wptr] <= push_data;
  end

endmodule

// File: rtl/uart_rx_buffered.sv
// Buffered UART receiver: synchronizer, frame FSM, FIFO, error flags.
// Define UART_RX_PARITY_EN for 8E1 framing with o_parity_err.
module uart_rx_buffered
  import uart_pkg::*;
#(
  parameter int CLKS_PER_BIT = UART_DEFAULT_CLKS_PER_BIT,
  parameter int FIFO_DEPTH   = 4
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       i_Rx,
  input  logic       rd_en,
  input  logic       clr_err,
  output logic [7:0] o_data,
  output logic       o_valid,
  output logic       o_frame_err,
`ifdef UART_RX_PARITY_EN
  output logic       o_parity_err,
`endif
  output logic       o_overrun
);

  localparam int CW = $clog2(CLKS_PER_BIT);
  localparam int IW = $clog2(UART_DATA_BITS);
  localparam logic [CW-1:0] LAST = CW'(CLKS_PER_BIT - 1);
  localparam logic [CW-1:0] HALF = CW'((CLKS_PER_BIT - 1) / 2);
  localparam logic [IW-1:0] TOP  = IW'(UART_DATA_BITS - 1);

  logic                      rx_m;
  logic                      rx_s;
  rx_state_e                 state;
  rx_state_e                 state_d;
  logic [CW-1:0]             cnt;
  logic [CW-1:0]             cnt_d;
  logic [IW-1:0]             idx;
  logic [IW-1:0]             idx_d;
  logic [UART_DATA_BITS-1:0] shift;
  logic [UART_DATA_BITS-1:0] shift_d;
  logic                      push;
  logic                      ferr_set;
  logic                      pop;
  logic                      full;
  logic                      empty;
  logic                      ovr_set;
  logic [$clog2(FIFO_DEPTH):0] count;

`ifdef UART_RX_PARITY_EN
  logic par_ok;
  logic par_ok_d;
  logic perr_set;
`endif

  // Two-flop synchronizer; idles high out of reset.
  always_ff @(posedge clk) begin
    if (rst) begin
      rx_m <= 1'b1;
      rx_s <= 1'b1;
    end else begin
      rx_m <= i_Rx;
      rx_s <= rx_m;
    end
  end

  // Frame FSM and datapath registers.
  always_ff @(posedge clk) begin
    if (rst) begin
      state <= IDLE;
      cnt   <= '0;
      idx   <= '0;
      shift <= '0;
`ifdef UART_RX_PARITY_EN
      par_ok <= 1'b1;
`endif
    end else begin
      state <= state_d;
      cnt   <= cnt_d;
      idx   <= idx_d;
      shift <= shift_d;
`ifdef UART_RX_PARITY_EN
      par_ok <= par_ok_d;
`endif
    end
  end

  // Next-state, bit sampling and push/error strobes.
  always_comb begin
    state_d  = state;
    cnt_d    = cnt + 1'b1;
    idx_d    = idx;
    shift_d  = shift;
    push     = 1'b0;
    ferr_set = 1'b0;
`ifdef UART_RX_PARITY_EN
    par_ok_d = par_ok;
    perr_set = 1'b0;
`endif
    unique case (state)
      IDLE: begin
        cnt_d = '0;
        if (!rx_s) state_d = START;
      end
      START: begin
        if (cnt == HALF) begin
          cnt_d   = '0;
          idx_d   = '0;
          state_d = rx_s ? IDLE : DATA;
        end
      end
      DATA: begin
        if (cnt == LAST) begin
          cnt_d        = '0;
          shift_d[idx] = rx_s;
          idx_d        = idx + 1'b1;
          if (idx == TOP) begin
`ifdef UART_RX_PARITY_EN
            state_d = PARITY;
`else
            state_d = STOP;
`endif
          end
        end
      end
`ifdef UART_RX_PARITY_EN
      PARITY: begin
        if (cnt == LAST) begin
          cnt_d    = '0;
          par_ok_d = ~^{shift, rx_s};
          perr_set = ^{shift, rx_s};
          state_d  = STOP;
        end
      end
`endif
      STOP: begin
        if (cnt == LAST) begin
          cnt_d = '0;
          if (rx_s) begin
`ifdef UART_RX_PARITY_EN
            push = par_ok;
`else
            push = 1'b1;
`endif
            state_d = IDLE;
          end else begin
            ferr_set = 1'b1;
            state_d  = WAIT_HIGH;
          end
        end
      end
      WAIT_HIGH: begin
        cnt_d = '0;
        if (rx_s) state_d = IDLE;
      end
      default: begin
        cnt_d   = '0;
        state_d = IDLE;
      end
    endcase
  end

  assign pop     = rd_en & ~empty;
  assign o_valid = (count != '0);
  assign ovr_set = push & full & ~pop;

  rx_byte_fifo #(
    .FIFO_DEPTH(FIFO_DEPTH)
  ) u_fifo (
    .clk       (clk),
    .rst       (rst),
    .push      (push),
    .push_data (shift),
    .pop       (pop),
    .rd_data   (o_data),
    .full      (full),
    .empty     (empty),
    .count     (count)
  );

  // Sticky error flags; a new event beats a clear.
  always_ff @(posedge clk) begin
    if (rst) begin
      o_frame_err <= 1'b0;
      o_overrun   <= 1'b0;
`ifdef UART_RX_PARITY_EN
      o_parity_err <= 1'b0;
`endif
    end else begin
      if (ferr_set)     o_frame_err <= 1'b1;
      else if (clr_err) o_frame_err <= 1'b0;
      if (ovr_set)      o_overrun <= 1'b1;
      else if (clr_err) o_overrun <= 1'b0;
`ifdef UART_RX_PARITY_EN
      if (perr_set)     o_parity_err <= 1'b1;
      else if (clr_err) o_parity_err <= 1'b0;
`endif
    end
  end

endmodule

// File: doc/uart_rx_buffered.md
Name: uart_rx_buffered

Overview:
UART receiver stage that sits directly upstream of the memory-mapped UART inside mem.
- Deserializes the asynchronous i_Rx line (8N1, LSB first) into bytes.
- Queues received bytes in a small FIFO.
- Presents the FIFO head, plus sticky error flags, to the memory-mapped read path used by the rv32i core.

Parameters:
CLKS_PER_BIT, 434, clk cycles per UART bit (50 MHz / 115200); minimum 4.
FIFO_DEPTH, 4, number of byte entries in the receive FIFO; must be a power of 2, minimum 2.

Ports:
clk  input  1  system clock; all logic on rising edge.
rst  input  1  synchronous, active-high reset.
i_Rx  input  1  asynchronous serial line, idle high.
rd_en  input  1  pop request; acts only when o_valid=1.
clr_err  input  1  clears o_frame_err and o_overrun.
o_data  output  8  FIFO head byte; holds 0 when empty.
o_valid  output  1  FIFO not empty.
o_frame_err  output  1  sticky: a stop bit was sampled low.
o_overrun  output  1  sticky: a byte arrived while the FIFO was full.

Behaviour:
Reset (rst=1 at a clk edge):
- FSM goes to IDLE; bit counter and clock counter are 0.
- FIFO empty; o_valid=0, o_data=0, flags=0.
- Both synchronizer flops = 1.
- Reset mid-frame abandons the partial byte; nothing is pushed.

Synchronizer:
- Two-flop synchronizer on i_Rx. All FSM sampling uses the synced value (rx_s).
- Input-to-FSM latency is 2 cycles.

FSM states:
- IDLE: rx_s=0 -> START, clock counter=0.
- START: when counter reaches (CLKS_PER_BIT-1)/2, sample rx_s. If 0 -> DATA, counter=0, bit index=0. If 1 -> IDLE (glitch rejected, no flag set).
- DATA: when counter reaches CLKS_PER_BIT-1, sample rx_s into shift[bit index] (LSB first), counter=0. After bit index 7 -> STOP.
- STOP: when counter reaches CLKS_PER_BIT-1, sample rx_s.
  - If 1: push the byte -> IDLE.
  - If 0: set o_frame_err, discard the byte -> WAIT_HIGH.
- WAIT_HIGH: stay until rx_s=1, then -> IDLE. This prevents a break condition from retriggering reception.

FIFO (first-word-fall-through):
- The pushed byte appears on o_data with o_valid=1 the cycle after the stop-sample edge.
- Pop when rd_en=1 and o_valid=1. The next head, or empty, is visible the following cycle.
- rd_en while empty: ignored.
- Push while full, with no pop in the same cycle: byte dropped, o_overrun set, FIFO contents unchanged.
- Push and pop in the same cycle while full: both take effect; no overrun.
- Push and pop in the same cycle while count=1: the new byte becomes the head; o_valid stays 1.
- Read/write pointers are clog2(FIFO_DEPTH) bits and wrap naturally. Count is clog2(FIFO_DEPTH)+1 bits.

Error flags:
- Sticky until clr_err.
- If clr_err and a new error event occur in the same cycle, the flag ends set (set wins).

Optional Feature:
UART_RX_PARITY_EN
- Defined: frame is 8E1. A PARITY state between DATA and STOP samples one extra bit, timed like a data bit.
  - Adds port o_parity_err (output, 1, sticky, cleared by clr_err, set wins).
  - A byte with a parity mismatch (XOR of data and parity bits != 0) is not pushed. The FSM still proceeds through STOP.
- Undefined: 8N1 only; no PARITY state and no o_parity_err port.

Decomposition:
- Package uart_pkg:
  - FSM state enum (IDLE, START, DATA, PARITY, STOP, WAIT_HIGH).
  - Constants UART_DATA_BITS=8 and UART_DEFAULT_CLKS_PER_BIT=434.
- Sub-module rx_byte_fifo, parameterized by FIFO_DEPTH, width 8: push/pop/full/empty/count. The top-level holds the synchronizer, FSM and flags.

Test Plan (CLKS_PER_BIT=16, FIFO_DEPTH=4):
- Single frame 0xA5 on i_Rx, rd_en=0 -> o_valid=1 and o_data=0xA5 one cycle after the stop sample; flags stay 0.
- Frames 0x01, 0x02, 0x03, 0x04, 0x05 with no reads -> FIFO holds 0x01..0x04 and o_overrun=1. Four pops return 0x01..0x04, then o_valid=0. Pulse clr_err -> o_overrun=0.
- Frame 0x3C with its stop bit driven low, then line high -> o_frame_err=1, o_valid=0. A following frame 0x7E is received normally.
- Low glitch on i_Rx of 4 cycles, then high -> FSM returns to IDLE; no push, no flag.
- FIFO full, rd_en=1 in the same cycle that frame 0x99 completes -> no overrun; 0x99 is enqueued at the tail; count stays 4.
- rst asserted mid-DATA of frame 0x55, then released with the line high -> o_valid=0 and flags 0. A following frame 0xC3 is received correctly.
